// File: rtl/cla64_mp_arb.sv
// Round-robin (per job) scheduler for one shared combinational 64-bit CLA adder.
// Streams multi-precision add/sub limbs, chains the carry and returns results through a 2-stage pipe.
module cla64_mp_arb #(
   parameter int LIDX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [127:0]      req_a,
   input  logic [127:0]      req_b,
   input  logic [1:0]        req_sub,
   input  logic [1:0]        req_last,
   output logic [63:0]       add_a,
   output logic [63:0]       add_b,
   output logic              add_cin,
   input  logic [63:0]       add_sum,
   input  logic              add_cout,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [63:0]       rsp_sum,
   output logic              rsp_cout,
   output logic              rsp_last,
   output logic              rsp_id,
   output logic [LIDX_W-1:0] rsp_idx
);

   typedef enum logic {UNLOCKED, LOCKED} arb_state_t;

   arb_state_t        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic              sub_job_q;
   logic              carry_q;
   logic              grant;
   logic              s1_load, s2_load, accept;
   logic              sub_in;
   logic [63:0]       sel_a, sel_b;
   logic [LIDX_W-1:0] idx_in;

   logic              op_valid, op_first, op_sub, op_last, op_id;
   logic [LIDX_W-1:0] op_idx;

   assign s2_load   = op_valid && (!rsp_valid || rsp_ready);
   assign s1_load   = !op_valid || s2_load;
   assign req_ready = s1_load ? (grant ? 2'b10 : 2'b01) : 2'b00;
   assign accept    = s1_load && req_valid[grant];
   assign sel_a     = grant ? req_a[127:64] : req_a[63:0];
   assign sel_b     = grant ? req_b[127:64] : req_b[63:0];
   assign sub_in    = (state_q == UNLOCKED) ? req_sub[grant] : sub_job_q;
   // op_idx keeps the previous limb's index after S1 drains, so it is the base for the next limb
   assign idx_in    = (state_q == UNLOCKED) ? '0 : op_idx + 1'b1;
   assign add_cin   = op_first ? op_sub : carry_q;

   always_comb begin
      grant        = !last_owner_q;
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      if (state_q == LOCKED) begin
         grant = owner_q;
      end else begin
         case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = !last_owner_q;
         endcase
      end
      if (accept) begin
         if (state_q == UNLOCKED) begin
            if (req_last[grant]) begin
               last_owner_d = grant;
            end else begin
               state_d = LOCKED;
               owner_d = grant;
            end
         end else if (req_last[grant]) begin
            state_d      = UNLOCKED;
            last_owner_d = owner_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= UNLOCKED;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         sub_job_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         if (accept && state_q == UNLOCKED)
            sub_job_q <= req_sub[grant];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_valid <= 1'b0;
         add_a    <= '0;
         add_b    <= '0;
         op_first <= 1'b0;
         op_sub   <= 1'b0;
         op_last  <= 1'b0;
         op_id    <= 1'b0;
         op_idx   <= '0;
      end else if (accept) begin
         op_valid <= 1'b1;
         add_a    <= sel_a;
         add_b    <= sub_in ? ~sel_b : sel_b;
         op_first <= (state_q == UNLOCKED);
         op_sub   <= sub_in;
         op_last  <= req_last[grant];
         op_id    <= grant;
         op_idx   <= idx_in;
      end else if (s1_load) begin
         op_valid <= 1'b0;
      end
   end

   // carry_q only advances when a limb moves into S2, so the successor always sees its predecessor's carry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_idx   <= '0;
         carry_q   <= 1'b0;
      end else if (s2_load) begin
         rsp_valid <= 1'b1;
         rsp_sum   <= add_sum;
         rsp_cout  <= add_cout;
         rsp_last  <= op_last;
         rsp_id    <= op_id;
         rsp_idx   <= op_idx;
         carry_q   <= add_cout;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cla64_mp_arb.sv
// Bench for cla64_mp_arb: whole-number reference model per job, per-requester scoreboards,
// directed arbitration/backpressure/reset steps followed by a randomized phase.
module tb_cla64_mp_arb;
   localparam int LIDX_W = 4;
   localparam int MAXL   = 20;
   localparam int W      = 64 * MAXL;

   logic              clk, rst_n;
   logic [1:0]        req_valid, req_ready, req_sub, req_last;
   logic [127:0]      req_a, req_b;
   logic [63:0]       add_a, add_b, add_sum;
   logic              add_cin, add_cout;
   logic              rsp_valid, rsp_ready, rsp_cout, rsp_last, rsp_id;
   logic [63:0]       rsp_sum;
   logic [LIDX_W-1:0] rsp_idx;

   cla64_mp_arb #(.LIDX_W(LIDX_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_last(req_last),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
      .rsp_cout(rsp_cout), .rsp_last(rsp_last), .rsp_id(rsp_id), .rsp_idx(rsp_idx)
   );

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0]       sum;
      logic              cout;
      logic              last;
      logic [LIDX_W-1:0] idx;
   } exp_t;

   typedef struct packed {
      logic              id;
      logic [LIDX_W-1:0] idx;
      int                cyc;
   } log_t;

   exp_t exp0[$];
   exp_t exp1[$];
   int   acc_log[$];
   log_t rsp_log[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   in_job = 1'b0;
   bit   cur_id = 1'b0;
   bit   done0, done1;
   exp_t mon_e;
   bit   mon_have;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: each limb's sum and carry come from a prefix addition of whole multi-limb numbers
   task automatic model_job(input int r, input int n, input bit sub,
                            input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] m, s;
      exp_t e;
      for (int i = 0; i < n; i++) begin
         m = ({{W{1'b0}}, 1'b1} << (64 * (i + 1))) - 1'b1;
         s = ({1'b0, a} & m) + ({1'b0, (sub ? ~b : b)} & m) + {{W{1'b0}}, sub};
         e.sum  = s[64*i +: 64];
         e.cout = s[64*(i+1)];
         e.last = (i == n - 1);
         e.idx  = LIDX_W'(i);
         if (r == 0) exp0.push_back(e);
         else        exp1.push_back(e);
      end
   endtask

   task automatic applyStimulus(input int r, input int n, input bit sub,
                                input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok;
      int tries;
      model_job(r, n, sub, a, b);
      for (int i = 0; i < n; i++) begin
         req_a[64*r +: 64] = a[64*i +: 64];
         req_b[64*r +: 64] = b[64*i +: 64];
         req_sub[r]  = (i == 0) ? sub : 1'($urandom);
         req_last[r] = (i == n - 1);
         req_valid[r] = 1'b1;
         ok = 1'b0;
         tries = 0;
         while (!ok && tries < 500) begin
            @(negedge clk);
            ok = req_ready[r];
            @(posedge clk);
            #1;
            tries++;
         end
         if (!ok) begin
            check("req_accept_timeout", 64'(ok), 64'd1);
            break;
         end
      end
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_job = 1'b0;
      acc_log.delete();
   endtask

   task automatic checkOutput();
      int t = 0;
      while ((exp0.size() + exp1.size()) != 0 && t < 600) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain", 64'(exp0.size() + exp1.size()), 64'd0);
   endtask

   function automatic logic [W-1:0] mk4(input logic [63:0] l0, l1, l2, l3);
      logic [W-1:0] v = '0;
      v[255:0] = {l3, l2, l1, l0};
      return v;
   endfunction

   function automatic logic [W-1:0] rnd_vec();
      logic [W-1:0] v;
      for (int i = 0; i < MAXL; i++) begin
         case ($urandom % 4)
            0:       v[64*i +: 64] = '1;
            1:       v[64*i +: 64] = '0;
            default: v[64*i +: 64] = {$urandom, $urandom};
         endcase
      end
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: record grants and score every delivered limb against its requester's queue
   always @(negedge clk) begin
      if (rst_n) begin
         for (int r = 0; r < 2; r++)
            if (req_valid[r] && req_ready[r]) acc_log.push_back(r);
         if (rsp_valid && rsp_ready) begin
            mon_have = (rsp_id == 1'b0) ? (exp0.size() != 0) : (exp1.size() != 0);
            check("rsp_expected", 64'(mon_have), 64'd1);
            if (mon_have) begin
               mon_e = (rsp_id == 1'b0) ? exp0.pop_front() : exp1.pop_front();
               check("rsp_sum", rsp_sum, mon_e.sum);
               check("rsp_cout", 64'(rsp_cout), 64'(mon_e.cout));
               check("rsp_last", 64'(rsp_last), 64'(mon_e.last));
               check("rsp_idx", 64'(rsp_idx), 64'(mon_e.idx));
            end
            if (in_job) check("job_contiguous", 64'(rsp_id), 64'(cur_id));
            in_job = !rsp_last;
            cur_id = rsp_id;
            rsp_log.push_back('{id: rsp_id, idx: rsp_idx, cyc: cyc});
         end
      end
   end

   initial begin
      logic [63:0] snap_sum;
      logic [8:0]  snap_ctl;
      int          base;
      rst_n = 1'b0;
      req_valid = '0; req_sub = '0; req_last = '0;
      req_a = '0; req_b = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_sum", rsp_sum, 64'd0);
      check("reset_add_a", add_a, 64'd0);
      check("reset_add_b", add_b, 64'd0);
      check("reset_add_cin", 64'(add_cin), 64'd0);
      rst_n = 1'b1;

      // single-limb add, exact latency
      applyStimulus(0, 1, 1'b0, mk4('1, 0, 0, 0), mk4(64'd1, 0, 0, 0));
      @(negedge clk);
      check("lat_add_a", add_a, 64'hFFFF_FFFF_FFFF_FFFF);
      check("lat_add_b", add_b, 64'd1);
      check("lat_rsp_not_yet", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      check("lat_rsp_valid", 64'(rsp_valid), 64'd1);
      check("lat_rsp_sum", rsp_sum, 64'd0);
      check("lat_rsp_cout", 64'(rsp_cout), 64'd1);
      check("lat_rsp_id", 64'(rsp_id), 64'd0);
      checkOutput();

      // 3-limb ripple from req1, back to back
      applyStimulus(1, 3, 1'b0, mk4('1, '1, 0, 0), mk4(64'd1, 0, 0, 0));
      checkOutput();
      base = rsp_log.size();
      check("ripple_back_to_back", 64'(rsp_log[base-1].cyc - rsp_log[base-3].cyc), 64'd2);

      // 2-limb subtract with borrow
      applyStimulus(0, 2, 1'b1, mk4(0, 64'd5, 0, 0), mk4(64'd1, 0, 0, 0));
      checkOutput();

      // arbitration from fresh reset: req0 first, req1 stalled during the lock
      applyReset();
      fork
         applyStimulus(0, 2, 1'b0, rnd_vec(), rnd_vec());
         applyStimulus(1, 2, 1'b1, rnd_vec(), rnd_vec());
         begin
            @(negedge clk);
            check("arb_tie_ready", 64'(req_ready), 64'd1);
            @(negedge clk);
            check("arb_locked_ready", 64'(req_ready), 64'd1);
         end
      join
      checkOutput();
      check("arb_order_size", 64'(acc_log.size()), 64'd4);
      if (acc_log.size() == 4) begin
         check("arb_order0", 64'(acc_log[0]), 64'd0);
         check("arb_order1", 64'(acc_log[1]), 64'd0);
         check("arb_order2", 64'(acc_log[2]), 64'd1);
         check("arb_order3", 64'(acc_log[3]), 64'd1);
      end
      acc_log.delete();
      fork
         applyStimulus(0, 2, 1'b1, rnd_vec(), rnd_vec());
         applyStimulus(1, 2, 1'b0, rnd_vec(), rnd_vec());
      join
      checkOutput();
      if (acc_log.size() >= 1) check("arb_second_round", 64'(acc_log[0]), 64'd0);
      else check("arb_second_round_size", 64'(acc_log.size()), 64'd4);

      // backpressure mid 4-limb job
      base = rsp_log.size();
      fork
         applyStimulus(0, 4, 1'b0, mk4('1, '1, 64'h1234, '1), mk4(64'd1, 0, '1, 64'd7));
         begin
            @(posedge clk);
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            snap_sum = rsp_sum;
            snap_ctl = {rsp_valid, rsp_cout, rsp_last, rsp_id, rsp_idx, add_cin};
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("bp_rsp_sum_hold", rsp_sum, snap_sum);
               check("bp_ctl_hold", 64'({rsp_valid, rsp_cout, rsp_last, rsp_id, rsp_idx, add_cin}),
                     64'(snap_ctl));
               check("bp_req_ready", 64'(req_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
         end
      join
      checkOutput();
      check("bp_delivered", 64'(rsp_log.size() - base), 64'd4);

      // reset mid-job
      rsp_ready = 1'b0;
      req_valid[0] = 1'b1; req_sub[0] = 1'b0; req_last[0] = 1'b0;
      req_a[63:0] = 64'h1234; req_b[63:0] = 64'h55;
      @(posedge clk); #1;
      req_a[63:0] = 64'h9876; req_b[63:0] = 64'h11;
      @(posedge clk); #1;
      check("rst_pre_valid", 64'(rsp_valid), 64'd1);
      rst_n = 1'b0;
      req_valid = '0;
      #1;
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_sum", rsp_sum, 64'd0);
      check("rst_add_a", add_a, 64'd0);
      check("rst_add_b", add_b, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_job = 1'b0;
      acc_log.delete();
      rsp_ready = 1'b1;
      applyStimulus(1, 2, 1'b0, rnd_vec(), rnd_vec());
      checkOutput();
      if (acc_log.size() >= 1) check("rst_fresh_grant", 64'(acc_log[0]), 64'd1);
      else check("rst_fresh_grant_size", 64'(acc_log.size()), 64'd2);

      // randomized jobs from both requesters with random backpressure, incl. an index wrap
      done0 = 1'b0;
      done1 = 1'b0;
      fork
         begin
            for (int k = 0; k < 12; k++) begin
               applyStimulus(0, 1 + int'($urandom % 5), 1'($urandom), rnd_vec(), rnd_vec());
               repeat ($urandom % 3) begin @(posedge clk); #1; end
            end
            done0 = 1'b1;
         end
         begin
            for (int k = 0; k < 12; k++) begin
               applyStimulus(1, (k == 5) ? 17 : 1 + int'($urandom % 5), 1'($urandom),
                             rnd_vec(), rnd_vec());
               repeat ($urandom % 3) begin @(posedge clk); #1; end
            end
            done1 = 1'b1;
         end
         begin
            while (!(done0 && done1)) begin
               @(posedge clk); #1;
               rsp_ready = ($urandom % 4) != 0;
            end
         end
      join
      rsp_ready = 1'b1;
      checkOutput();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
